// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types and helpers for the clock set controller:
//                FSM state encoding, display field codes, BCD split/join and
//                wrap-around increment helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN          = 3'd0,
        ST_SET_TIME_H   = 3'd1,
        ST_SET_TIME_M   = 3'd2,
        ST_SET_ALARM_H  = 3'd3,
        ST_SET_ALARM_M  = 3'd4,
        ST_COMMIT_TIME  = 3'd5,
        ST_COMMIT_ALARM = 3'd6,
        ST_DISMISS      = 3'd7
    } state_t;

    // Field being edited, drives display blinking
    localparam logic [1:0] FIELD_NONE   = 2'b00;
    localparam logic [1:0] FIELD_TIME_H = 2'b01;
    localparam logic [1:0] FIELD_TIME_M = 2'b10;
    localparam logic [1:0] FIELD_ALARM  = 2'b11;

    // BCD hours (tens, units) to binary 0..23
    function automatic logic [4:0] bcd_join_h(input logic [1:0] h1, input logic [3:0] h0);
        return 5'(h1) * 5'd10 + 5'(h0);
    endfunction

    // BCD minutes (tens, units) to binary 0..59
    function automatic logic [5:0] bcd_join_m(input logic [2:0] m1, input logic [3:0] m0);
        return 6'(m1) * 6'd10 + 6'(m0);
    endfunction

    // Binary hours to packed {tens[1:0], units[3:0]}
    function automatic logic [5:0] bcd_split_h(input logic [4:0] h);
        logic [1:0] t;
        logic [3:0] u;
        t = 2'(h / 5'd10);
        u = 4'(h % 5'd10);
        return {t, u};
    endfunction

    // Binary minutes to packed {tens[2:0], units[3:0]}
    function automatic logic [6:0] bcd_split_m(input logic [5:0] m);
        logic [2:0] t;
        logic [3:0] u;
        t = 3'(m / 6'd10);
        u = 4'(m % 6'd10);
        return {t, u};
    endfunction

    // Hour increment with 23 -> 0 wrap
    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // Minute increment with 59 -> 0 wrap
    function automatic logic [5:0] min_inc(input logic [5:0] m);
        return (m >= 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_controller_hold_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hold_counter
//  Description : Up-counter with synchronous clear and enable. done_o flags
//                the TERMINAL-th enabled cycle after a clear; the count then
//                holds until the next clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module hold_counter #(
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam int WIDTH = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign done_o = (count_q == WIDTH'(TERMINAL - 1));

    // Next count: clear wins, otherwise advance until terminal
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !done_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_controller
//  Description : Button-driven time/alarm setting FSM for a BCD clock
//                datapath. Edits hours/minutes, commits them with held load
//                strobes, handles snooze and alarm dismiss, and abandons an
//                idle edit after TIMEOUT_CYC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_set_controller #(
    parameter int LOAD_HOLD   = 4,
    parameter int SNOOZE_MIN  = 5,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       alarm,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [2:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] H1,
    output logic [3:0] H0,
    output logic [2:0] M1,
    output logic [3:0] M0,
    output logic       load_time,
    output logic       load_alarm,
    output logic       off_alarm,
    output logic       edit_active,
    output logic [1:0] field_sel
);

    import clock_pkg::*;

    state_t     state_q, state_d;
    logic [4:0] edit_hour_q, edit_hour_d;
    logic [5:0] edit_min_q, edit_min_d;
    logic [4:0] sh_hour_q, sh_hour_d;
    logic [5:0] sh_min_q, sh_min_d;
    logic       snooze_q, snooze_d;
    logic       load_time_q, load_time_d;
    logic       load_alarm_q, load_alarm_d;
    logic       off_alarm_q, off_alarm_d;
    logic       edit_active_q, edit_active_d;
    logic [1:0] field_sel_q, field_sel_d;

    logic       snooze_go;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [4:0] snz_hour;
    logic [5:0] snz_min;
    logic [6:0] snz_sum;
    logic       hold_done;
    logic       idle_done;
    logic       state_change;
    logic       any_btn;
    logic       in_commit;
    logic       in_set;

    assign cur_hour = bcd_join_h(cur_h1, cur_h0);
    assign cur_min  = bcd_join_m(cur_m1, cur_m0);

    assign {H1, H0} = bcd_split_h(edit_hour_q);
    assign {M1, M0} = bcd_split_m(edit_min_q);

    assign load_time   = load_time_q;
    assign load_alarm  = load_alarm_q;
    assign off_alarm   = off_alarm_q;
    assign edit_active = edit_active_q;
    assign field_sel   = field_sel_q;

    assign state_change = (state_d != state_q);
    assign any_btn      = btn_mode | btn_next | btn_inc;
    assign in_commit    = (state_q == ST_COMMIT_TIME) || (state_q == ST_COMMIT_ALARM)
                       || (state_q == ST_DISMISS);
    assign in_set       = (state_q == ST_SET_TIME_H) || (state_q == ST_SET_TIME_M)
                       || (state_q == ST_SET_ALARM_H) || (state_q == ST_SET_ALARM_M);

    // Strobe duration: restarts on every state entry, runs only while committing
    hold_counter #(.TERMINAL(LOAD_HOLD)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_change),
        .en_i    (in_commit),
        .done_o  (hold_done)
    );

    // Edit inactivity: restarts on any button press or state entry
    hold_counter #(.TERMINAL(TIMEOUT_CYC)) u_idle (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_change | any_btn),
        .en_i    (in_set),
        .done_o  (idle_done)
    );

    // Snooze target: current time plus SNOOZE_MIN with minute/hour carry
    always_comb begin
        snz_sum  = 7'(cur_min) + 7'(SNOOZE_MIN);
        snz_hour = cur_hour;
        snz_min  = 6'(snz_sum);
        if (snz_sum >= 7'd60) begin
            snz_min  = 6'(snz_sum - 7'd60);
            snz_hour = hour_inc(cur_hour);
        end
    end

    // Next-state and edit register logic; button priority mode > next > inc
    always_comb begin
        state_d     = state_q;
        edit_hour_d = edit_hour_q;
        edit_min_d  = edit_min_q;
        snooze_go   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (btn_mode) begin
                    if (alarm) begin
                        state_d = ST_DISMISS;
                    end else begin
                        state_d     = ST_SET_TIME_H;
                        edit_hour_d = cur_hour;
                        edit_min_d  = cur_min;
                    end
                end else if (!btn_next && btn_inc && alarm) begin
                    state_d     = ST_COMMIT_ALARM;
                    edit_hour_d = snz_hour;
                    edit_min_d  = snz_min;
                    snooze_go   = 1'b1;
                end
            end
            ST_SET_TIME_H, ST_SET_ALARM_H: begin
                if (btn_mode) begin
                    if (state_q == ST_SET_TIME_H) begin
                        state_d     = ST_SET_ALARM_H;
                        edit_hour_d = sh_hour_q;
                        edit_min_d  = sh_min_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (btn_next) begin
                    state_d = (state_q == ST_SET_TIME_H) ? ST_SET_TIME_M : ST_SET_ALARM_M;
                end else if (btn_inc) begin
                    edit_hour_d = hour_inc(edit_hour_q);
                end else if (idle_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_TIME_M, ST_SET_ALARM_M: begin
                if (btn_mode) begin
                    if (state_q == ST_SET_TIME_M) begin
                        state_d     = ST_SET_ALARM_H;
                        edit_hour_d = sh_hour_q;
                        edit_min_d  = sh_min_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (btn_next) begin
                    state_d = (state_q == ST_SET_TIME_M) ? ST_COMMIT_TIME : ST_COMMIT_ALARM;
                end else if (btn_inc) begin
                    edit_min_d = min_inc(edit_min_q);
                end else if (idle_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_COMMIT_TIME, ST_COMMIT_ALARM, ST_DISMISS: begin
                if (hold_done) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state; shadow captured on alarm commit entry
    always_comb begin
        load_time_d   = (state_d == ST_COMMIT_TIME);
        load_alarm_d  = (state_d == ST_COMMIT_ALARM);
        snooze_d      = (state_d == ST_COMMIT_ALARM) && (snooze_go || snooze_q);
        off_alarm_d   = (state_d == ST_DISMISS) || snooze_d;
        edit_active_d = (state_d == ST_SET_TIME_H) || (state_d == ST_SET_TIME_M)
                     || (state_d == ST_SET_ALARM_H) || (state_d == ST_SET_ALARM_M);
        case (state_d)
            ST_SET_TIME_H:                  field_sel_d = FIELD_TIME_H;
            ST_SET_TIME_M:                  field_sel_d = FIELD_TIME_M;
            ST_SET_ALARM_H, ST_SET_ALARM_M: field_sel_d = FIELD_ALARM;
            default:                        field_sel_d = FIELD_NONE;
        endcase
        sh_hour_d = sh_hour_q;
        sh_min_d  = sh_min_q;
        if ((state_d == ST_COMMIT_ALARM) && (state_q != ST_COMMIT_ALARM)) begin
            sh_hour_d = edit_hour_d;
            sh_min_d  = edit_min_d;
        end
    end

    // State, edit, shadow and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            edit_hour_q   <= '0;
            edit_min_q    <= '0;
            sh_hour_q     <= '0;
            sh_min_q      <= '0;
            snooze_q      <= 1'b0;
            load_time_q   <= 1'b0;
            load_alarm_q  <= 1'b0;
            off_alarm_q   <= 1'b0;
            edit_active_q <= 1'b0;
            field_sel_q   <= FIELD_NONE;
        end else begin
            state_q       <= state_d;
            edit_hour_q   <= edit_hour_d;
            edit_min_q    <= edit_min_d;
            sh_hour_q     <= sh_hour_d;
            sh_min_q      <= sh_min_d;
            snooze_q      <= snooze_d;
            load_time_q   <= load_time_d;
            load_alarm_q  <= load_alarm_d;
            off_alarm_q   <= off_alarm_d;
            edit_active_q <= edit_active_d;
            field_sel_q   <= field_sel_d;
        end
    end

endmodule
`default_nettype wire
